// File: rtl/pwm_duty_decoder.sv
// pwm_duty_decoder: measures period/high time of a PWM line and quantises duty to STEPS+1 levels
module pwm_duty_decoder #(
  parameter int CNT_W   = 16,
  parameter int STEPS   = 10,
  parameter int TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic             valid,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic [3:0]       duty_step,
  output logic             stuck,
  output logic             overrun
);
  localparam int NW = CNT_W + 5;
  typedef enum logic [1:0] {IDLE, MEASURE, STUCK} state_t;
  state_t           r_state;
  logic             r_s1, r_s2, r_s3;
  logic [CNT_W-1:0] r_pcnt, r_hcnt, r_p, r_h;
  logic [NW-1:0]    r_rem;
  logic [3:0]       r_q;
  logic [2:0]       r_stg;
  logic             w_rise, w_busy, w_tout, w_start, w_ge;
  logic [NW-1:0]    w_num, w_dsh;
  logic [3:0]       w_qn;
  always_comb begin
    w_rise  = r_s2 & ~r_s3;
    w_busy  = r_stg != 3'd0;
    w_tout  = r_state != STUCK && r_pcnt == CNT_W'(TIMEOUT);
    w_start = w_rise && r_state == MEASURE && !w_busy;
    w_num   = NW'(r_hcnt) * NW'(STEPS) + NW'(r_pcnt >> 1);
    // stages 1..4 resolve quotient bits 3..0; stage 5 only keeps the divider busy
    w_dsh   = NW'(r_p) << (3'd4 - r_stg);
    w_ge    = r_rem >= w_dsh;
    w_qn    = {r_q[2:0], w_ge};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_s3       <= 1'b0;
      r_pcnt     <= '0;
      r_hcnt     <= '0;
      r_p        <= '0;
      r_h        <= '0;
      r_rem      <= '0;
      r_q        <= '0;
      r_stg      <= '0;
      valid      <= 1'b0;
      period_out <= '0;
      high_out   <= '0;
      duty_step  <= '0;
      stuck      <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      r_s1  <= pwm_in;
      r_s2  <= r_s1;
      r_s3  <= r_s2;
      valid <= 1'b0;
      if (w_rise) begin
        r_state <= MEASURE;
        r_pcnt  <= CNT_W'(1);
        r_hcnt  <= CNT_W'(1);
        if (r_state == MEASURE && w_busy) overrun <= 1'b1;
      end else if (w_tout) begin
        r_state    <= STUCK;
        valid      <= 1'b1;
        period_out <= '0;
        high_out   <= '0;
        duty_step  <= r_s2 ? 4'(STEPS) : 4'd0;
        stuck      <= 1'b1;
      end else if (r_state != STUCK) begin
        r_pcnt <= r_pcnt + CNT_W'(1);
        r_hcnt <= r_hcnt + CNT_W'(r_s2);
      end
      if (w_start) begin
        r_stg <= 3'd1;
        r_p   <= r_pcnt;
        r_h   <= r_hcnt;
        r_rem <= w_num;
        r_q   <= 4'd0;
      end else if (w_busy) begin
        r_stg <= r_stg == 3'd5 ? 3'd0 : r_stg + 3'd1;
        if (r_stg != 3'd5) begin
          r_q <= w_qn;
          if (w_ge) r_rem <= r_rem - w_dsh;
        end
        if (r_stg == 3'd4) begin
          valid      <= 1'b1;
          period_out <= r_p;
          high_out   <= r_h;
          duty_step  <= w_qn > 4'(STEPS) ? 4'(STEPS) : w_qn;
          stuck      <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_pwm_duty_decoder.sv
// tb_pwm_duty_decoder: randomized + directed scoreboard bench for pwm_duty_decoder
module tb_pwm_duty_decoder;
  localparam int S = 10;
  localparam int T = 1000;
  localparam int M_IDLE = 0, M_MEAS = 1, M_STUCK = 2;
  typedef struct {int cyc; int p; int h; int d; bit st;} exp_t;
  logic        clk, rst, pwm_in, valid, stuck, overrun;
  logic [15:0] period_out, high_out;
  logic [3:0]  duty_step;
  int          tests, fails, cyc;
  exp_t        q[$];
  exp_t        e;
  int          m_mode, m_last, m_high, m_busy_end;
  bit          m_prev, m_ovr;
  pwm_duty_decoder #(.CNT_W(16), .STEPS(S), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in), .valid(valid), .period_out(period_out),
    .high_out(high_out), .duty_step(duty_step), .stuck(stuck), .overrun(overrun)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  // reference: sample k of the line is seen by the DUT two cycles later; reports land 7 cycles after sample k
  task automatic model(input int k, input bit v);
    int p, d;
    if (v && !m_prev) begin
      if (m_mode == M_MEAS) begin
        if (k < m_busy_end) m_ovr = 1'b1;
        else begin
          p = k - m_last;
          d = (m_high * S + p / 2) / p;
          if (d > S) d = S;
          q.push_back('{k + 7, p, m_high, d, 1'b0});
          m_busy_end = k + 6;
        end
      end
      m_mode = M_MEAS;
      m_last = k;
      m_high = 0;
    end else if (m_mode != M_STUCK && k - m_last == T) begin
      q.push_back('{k + 3, 0, 0, v ? S : 0, 1'b1});
      m_mode = M_STUCK;
    end
    m_high += int'(v);
    m_prev = v;
  endtask
  task automatic step(input bit v);
    @(posedge clk);
    #1 pwm_in = v;
    model(cyc, v);
  endtask
  task automatic wave(input int p, input int h, input int n);
    for (int j = 0; j < n; j++)
      for (int i = 0; i < p; i++) step(i < h);
  endtask
  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_mode = M_IDLE;
    m_last = cyc - 2;
    m_prev = 1'b0;
    m_ovr = 1'b0;
    m_busy_end = -100;
    m_high = 0;
    model(cyc, pwm_in);
    @(negedge clk);
    tests++;
    if ({valid, period_out, high_out, duty_step, stuck, overrun} !== '0) begin
      fails++;
      $display("FAIL reset_state: valid %0b period %0d high %0d step %0d stuck %0b overrun %0b, required all 0",
               valid, period_out, high_out, duty_step, stuck, overrun);
    end
  endtask
  task automatic chk(input string name);
    repeat (12) step(pwm_in);
    tests++;
    if (overrun !== m_ovr) begin
      fails++;
      $display("FAIL %s: overrun %0b, required %0b", name, overrun, m_ovr);
    end
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (q.size() != 0 && q[0].cyc < cyc) begin
        tests++;
        fails++;
        $display("FAIL missing_valid: no strobe at cycle %0d, required period %0d high %0d step %0d",
                 q[0].cyc, q[0].p, q[0].h, q[0].d);
        q.delete(0);
      end
      if (valid) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_valid: cycle %0d period %0d high %0d step %0d, required no strobe",
                   cyc, period_out, high_out, duty_step);
        end else begin
          e = q[0];
          q.delete(0);
          if (e.cyc != cyc || period_out != 16'(e.p) || high_out != 16'(e.h) || duty_step != 4'(e.d) || stuck != e.st) begin
            fails++;
            $display("FAIL report: cycle %0d period %0d high %0d step %0d stuck %0b, required cycle %0d period %0d high %0d step %0d stuck %0b",
                     cyc, period_out, high_out, duty_step, stuck, e.cyc, e.p, e.h, e.d, e.st);
          end
        end
      end
    end
  end
  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    pwm_in = 1'b0;
    do_reset();
    wave(10, 3, 6);
    chk("basic_10_3");
    for (int h = 0; h <= 10; h++) wave(10, h, 4);
    wave(7, 3, 4);
    wave(7, 2, 4);
    chk("sweep_round");
    do_reset();
    repeat (5) step(1'b0);
    repeat (1100) step(1'b1);
    wave(10, 5, 4);
    chk("stuck_high");
    do_reset();
    repeat (1100) step(1'b0);
    chk("stuck_low");
    do_reset();
    wave(4, 2, 6);
    chk("overrun_set");
    do_reset();
    wave(6, 3, 6);
    chk("period6_clean");
    do_reset();
    wave(10, 4, 2);
    repeat (2) step(1'b1);
    do_reset();
    wave(10, 4, 4);
    chk("reset_mid");
    do_reset();
    for (int r = 0; r < 60; r++) begin
      int p;
      p = ($urandom_range(0, 9) == 0) ? $urandom_range(2, 5) : $urandom_range(6, 40);
      wave(p, $urandom_range(0, p), $urandom_range(1, 3));
    end
    chk("random");
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d reports outstanding, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
